// File: rtl/fft_frame_collector_pkg.sv
// Shared types and helpers for the FFT frame collector: the 64-bit complex
// sample, the channel-index width rule and the bit-reversal index function.
package fft_frame_collector_pkg;

    localparam int SAMPLE_W = 32;
    localparam int MAX_CH   = 8;
    localparam int CH_IDX_W = 3;  // enough bits to tag any of MAX_CH channels

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] r;
        logic signed [SAMPLE_W-1:0] i;
    } complex_product_t;

    // Channel tag width: one bit minimum, even for a single channel.
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Reverse the low 'bits' bits of k (frames up to 1024 samples).
    function automatic logic [9:0] bitrev(input logic [9:0] k, input int bits);
        logic [9:0] res;
        res = '0;
        for (int b = 0; b < 10; b++) begin
            if (b < bits) res[b] = k[bits-1-b];
        end
        return res;
    endfunction

endpackage

// File: rtl/fft_rr_arbiter.sv
// Round-robin arbiter: picks one requesting channel, starting the search just
// after the previously granted one.
module fft_rr_arbiter
    import fft_frame_collector_pkg::*;
#(
    parameter int NUM_CH = 2,
    localparam int CH_W  = ch_idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx
);

    logic [CH_W-1:0] last_grant;
    logic            found;
    int              cand;

    // Search requests from last_grant+1 and grant the first one found.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int off = 1; off <= NUM_CH; off++) begin
            cand = (int'(last_grant) + off) % NUM_CH;
            if (!found && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = CH_W'(cand);
                found       = 1'b1;
            end
        end
    end

    // Remember the winner whenever a grant is actually taken.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant <= CH_W'(NUM_CH - 1);
        end else if (advance && (|req)) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/fft_frame_collector.sv
// Collects per-channel sample streams into N-sample frames and hands complete
// frames, one at a time, to a single valid/ready output slot.
module fft_frame_collector
    import fft_frame_collector_pkg::*;
#(
    parameter int N       = 8,
    parameter int NUM_CH  = 2,
    parameter int BIT_REV = 0,
    localparam int CH_W   = ch_idx_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     in_valid,
    input  logic [CH_W-1:0]          in_ch,
    input  complex_product_t         data_in,
    output logic                     in_ready,
    output complex_product_t [N-1:0] frame_out,
    output logic [CH_W-1:0]          frame_ch,
    output logic                     frame_valid,
    input  logic                     frame_ready,
    output logic                     overflow
);

    localparam int   LOG2N      = $clog2(N);
    localparam logic CH_FILLING = 1'b0;
    localparam logic CH_FULL    = 1'b1;
    localparam logic SLOT_EMPTY = 1'b0;
    localparam logic SLOT_VALID = 1'b1;

    logic [NUM_CH-1:0] ch_state;
    logic [LOG2N-1:0]  cnt [NUM_CH];
    complex_product_t  ch_buf [NUM_CH][N];
    logic              slot_state;
    logic              accept;
    logic              slot_free;
    logic              do_grant;
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   grant_idx;

    // Buffer index for fill position c: natural or bit-reversed order.
    function automatic logic [LOG2N-1:0] store_idx(input logic [LOG2N-1:0] c);
        if (BIT_REV != 0) return LOG2N'(bitrev(10'(c), LOG2N));
        else              return c;
    endfunction

    // Ready only for an existing channel that is still filling.
    always_comb begin
        in_ready = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(in_ch) == c && ch_state[c] == CH_FILLING) in_ready = enable;
        end
    end

    assign accept      = in_valid & in_ready;
    assign slot_free   = (slot_state == SLOT_EMPTY) | frame_ready;
    assign do_grant    = slot_free & (|ch_state);
    assign frame_valid = (slot_state == SLOT_VALID);

    fft_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (ch_state),
        .advance   (slot_free),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Per-channel fill counter and FILLING/FULL state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ch_state[c] <= CH_FILLING;
                cnt[c]      <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (do_grant && grant[c]) begin
                    ch_state[c] <= CH_FILLING;
                    cnt[c]      <= '0;
                end else if (accept && int'(in_ch) == c) begin
                    cnt[c] <= cnt[c] + 1'b1;
                    if (cnt[c] == LOG2N'(N - 1)) ch_state[c] <= CH_FULL;
                end
            end
        end
    end

    // Sample storage; stale contents are harmless because cnt restarts at 0.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (accept && int'(in_ch) == c) ch_buf[c][store_idx(cnt[c])] <= data_in;
        end
    end

    // Output slot: load a granted frame, drain when consumed, track overflow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            slot_state <= SLOT_EMPTY;
            frame_ch   <= '0;
            frame_out  <= '0;
            overflow   <= 1'b0;
        end else begin
            if (do_grant) begin
                slot_state <= SLOT_VALID;
                frame_ch   <= grant_idx;
                for (int c = 0; c < NUM_CH; c++) begin
                    if (grant[c]) begin
                        for (int k = 0; k < N; k++) frame_out[k] <= ch_buf[c][k];
                    end
                end
            end else if (frame_ready) begin
                slot_state <= SLOT_EMPTY;
            end
            if (in_valid && !in_ready) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fft_frame_collector.sv
// Directed bench for fft_frame_collector (N=8, NUM_CH=2), natural and
// bit-reversed instances driven by the same stimulus.
module tb_fft_frame_collector;
    import fft_frame_collector_pkg::*;

    logic clk = 1'b0;
    logic reset, enable, in_valid, frame_ready;
    logic [0:0] in_ch;
    complex_product_t data_in;

    logic in_ready_n, frame_valid_n, overflow_n;
    logic [0:0] frame_ch_n;
    complex_product_t [7:0] frame_out_n;

    logic in_ready_r, frame_valid_r, overflow_r;
    logic [0:0] frame_ch_r;
    complex_product_t [7:0] frame_out_r;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fft_frame_collector #(.N(8), .NUM_CH(2), .BIT_REV(0)) u_nat (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
        .in_ch(in_ch), .data_in(data_in), .in_ready(in_ready_n),
        .frame_out(frame_out_n), .frame_ch(frame_ch_n), .frame_valid(frame_valid_n),
        .frame_ready(frame_ready), .overflow(overflow_n)
    );

    fft_frame_collector #(.N(8), .NUM_CH(2), .BIT_REV(1)) u_rev (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
        .in_ch(in_ch), .data_in(data_in), .in_ready(in_ready_r),
        .frame_out(frame_out_r), .frame_ch(frame_ch_r), .frame_valid(frame_valid_r),
        .frame_ready(frame_ready), .overflow(overflow_r)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [0:0] ch, input int r);
        in_valid  = 1'b1;
        in_ch     = ch;
        data_in.r = r;
        data_in.i = 0;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic fill(input logic [0:0] ch, input int base);
        for (int k = 0; k < 8; k++) send(ch, base + k);
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        reset    = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b1; in_valid = 1'b0; in_ch = 1'b0;
        frame_ready = 1'b1; data_in = '0;
        tick(); tick();
        tests++; if (frame_valid_n !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", frame_valid_n); end
        tests++; if (frame_ch_n !== 1'b0) begin fails++; $display("FAIL reset_ch got %b want 0", frame_ch_n); end
        tests++; if (overflow_n !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", overflow_n); end
        tests++; if (frame_out_n !== '0) begin fails++; $display("FAIL reset_frame got %h want 0", frame_out_n); end
        tests++; if (in_ready_n !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", in_ready_n); end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        frame_ready = 1'b1;
        fill(1'b0, 0);
        tests++; if (frame_valid_n !== 1'b0) begin fails++; $display("FAIL basic_early got %b want 0", frame_valid_n); end
        tick();
        tests++; if (frame_valid_n !== 1'b1) begin fails++; $display("FAIL basic_valid got %b want 1", frame_valid_n); end
        tests++; if (frame_ch_n !== 1'b0) begin fails++; $display("FAIL basic_ch got %b want 0", frame_ch_n); end
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (frame_out_n[k].r !== k || frame_out_n[k].i !== 0) begin
                fails++; $display("FAIL basic_data[%0d] got r=%0d i=%0d want r=%0d i=0", k, frame_out_n[k].r, frame_out_n[k].i, k);
            end
        end
        tick();
        tests++; if (frame_valid_n !== 1'b0) begin fails++; $display("FAIL basic_drain got %b want 0", frame_valid_n); end
    endtask

    task automatic test_bitrev();
        int exp_r[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        frame_ready = 1'b1;
        fill(1'b0, 0);
        tick();
        tests++; if (frame_valid_r !== 1'b1) begin fails++; $display("FAIL rev_valid got %b want 1", frame_valid_r); end
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (frame_out_r[k].r !== exp_r[k]) begin
                fails++; $display("FAIL rev_data[%0d] got %0d want %0d", k, frame_out_r[k].r, exp_r[k]);
            end
        end
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        frame_ready = 1'b0;
        fill(1'b1, 200);
        tick();
        tests++; if (frame_ch_n !== 1'b1 || frame_valid_n !== 1'b1) begin fails++; $display("FAIL rr_hold got ch=%b v=%b want ch=1 v=1", frame_ch_n, frame_valid_n); end
        for (int round = 0; round < 2; round++) begin
            fill(1'b0, 10 + 20 * round);
            fill(1'b1, 20 + 20 * round);
            tests++; if (frame_out_n[0].r !== 200 && round == 0) begin fails++; $display("FAIL rr_stable got %0d want 200", frame_out_n[0].r); end
            frame_ready = 1'b1;
            tick();
            tests++;
            if (frame_ch_n !== 1'b0 || frame_out_n[3].r !== 13 + 20 * round) begin
                fails++; $display("FAIL rr_first_%0d got ch=%b r3=%0d want ch=0 r3=%0d", round, frame_ch_n, frame_out_n[3].r, 13 + 20 * round);
            end
            tick();
            tests++;
            if (frame_ch_n !== 1'b1 || frame_valid_n !== 1'b1 || frame_out_n[3].r !== 23 + 20 * round) begin
                fails++; $display("FAIL rr_second_%0d got ch=%b v=%b r3=%0d want ch=1 v=1 r3=%0d", round, frame_ch_n, frame_valid_n, frame_out_n[3].r, 23 + 20 * round);
            end
            frame_ready = 1'b0;
        end
        frame_ready = 1'b1;
        tick();
        tests++; if (frame_valid_n !== 1'b0) begin fails++; $display("FAIL rr_empty got %b want 0", frame_valid_n); end
    endtask

    task automatic test_backpressure();
        do_reset();
        frame_ready = 1'b0;
        fill(1'b0, 50);
        tick();
        tests++; if (frame_valid_n !== 1'b1) begin fails++; $display("FAIL bp_valid got %b want 1", frame_valid_n); end
        fill(1'b0, 60);
        in_ch = 1'b0;
        #1;
        tests++; if (in_ready_n !== 1'b0) begin fails++; $display("FAIL bp_ready got %b want 0", in_ready_n); end
        tests++; if (frame_out_n[0].r !== 50) begin fails++; $display("FAIL bp_stable got %0d want 50", frame_out_n[0].r); end
        tests++; if (overflow_n !== 1'b0) begin fails++; $display("FAIL bp_no_ovf got %b want 0", overflow_n); end
        send(1'b0, 99);
        tests++; if (overflow_n !== 1'b1) begin fails++; $display("FAIL bp_ovf got %b want 1", overflow_n); end
        tests++; if (frame_out_n[7].r !== 57) begin fails++; $display("FAIL bp_stable2 got %0d want 57", frame_out_n[7].r); end
        frame_ready = 1'b1;
        tick();
        tests++;
        if (frame_valid_n !== 1'b1 || frame_out_n[0].r !== 60 || frame_out_n[7].r !== 67) begin
            fails++; $display("FAIL bp_second got v=%b r0=%0d r7=%0d want v=1 r0=60 r7=67", frame_valid_n, frame_out_n[0].r, frame_out_n[7].r);
        end
        tick();
        tests++; if (in_ready_n !== 1'b1) begin fails++; $display("FAIL bp_refill_ready got %b want 1", in_ready_n); end
    endtask

    task automatic test_reset_midframe();
        frame_ready = 1'b1;
        for (int k = 1; k <= 5; k++) send(1'b1, k);
        do_reset();
        tests++; if (overflow_n !== 1'b0) begin fails++; $display("FAIL mid_ovf got %b want 0", overflow_n); end
        tests++; if (frame_valid_n !== 1'b0 || frame_ch_n !== 1'b0) begin fails++; $display("FAIL mid_out got v=%b ch=%b want 0 0", frame_valid_n, frame_ch_n); end
        tests++; if (frame_out_n !== '0) begin fails++; $display("FAIL mid_frame got %h want 0", frame_out_n); end
        fill(1'b1, 100);
        tick();
        tests++; if (frame_valid_n !== 1'b1 || frame_ch_n !== 1'b1) begin fails++; $display("FAIL mid_new got v=%b ch=%b want 1 1", frame_valid_n, frame_ch_n); end
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (frame_out_n[k].r !== 100 + k) begin
                fails++; $display("FAIL mid_data[%0d] got %0d want %0d", k, frame_out_n[k].r, 100 + k);
            end
        end
        tick();
    endtask

    task automatic test_enable();
        do_reset();
        frame_ready = 1'b1;
        enable = 1'b0;
        in_valid = 1'b1; in_ch = 1'b0; data_in.r = 99; data_in.i = 0;
        #1;
        tests++; if (in_ready_n !== 1'b0) begin fails++; $display("FAIL en_ready got %b want 0", in_ready_n); end
        tick();
        in_valid = 1'b0;
        tests++; if (overflow_n !== 1'b1) begin fails++; $display("FAIL en_ovf got %b want 1", overflow_n); end
        enable = 1'b1;
        fill(1'b0, 70);
        tick();
        tests++;
        if (frame_valid_n !== 1'b1 || frame_out_n[0].r !== 70 || frame_out_n[7].r !== 77) begin
            fails++; $display("FAIL en_frame got v=%b r0=%0d r7=%0d want v=1 r0=70 r7=77", frame_valid_n, frame_out_n[0].r, frame_out_n[7].r);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bitrev();
        test_round_robin();
        test_backpressure();
        test_reset_midframe();
        test_enable();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
